// File: rtl/copperv_bus_pkg.sv
// Shared definitions for the CPU data-bus responder.
//   BUS_RESP_OKAY / BUS_RESP_ERROR : write response codes
//   BUS_DEADBEEF                   : read fill value for out-of-range addresses
//   resp_entry_t                   : one slot of a response delay queue
//                                    (payload + age counter)
package copperv_bus_pkg;

  localparam logic BUS_RESP_OKAY  = 1'b0;
  localparam logic BUS_RESP_ERROR = 1'b1;

  localparam logic [31:0] BUS_DEADBEEF = 32'hDEADBEEF;

  // Payload field is sized for the widest channel; narrower channels
  // zero-extend into it and read back only their low bits.
  localparam int BUS_MAX_PAYLOAD_W = 64;
  // Age counter width; latencies up to 255 cycles are supported.
  localparam int BUS_AGE_W = 8;

  typedef struct packed {
    logic [BUS_MAX_PAYLOAD_W-1:0] payload;
    logic [BUS_AGE_W-1:0]         age;
  } resp_entry_t;

endpackage

// File: rtl/resp_delay_queue.sv
// In-order response FIFO where every entry carries an age counter. An
// entry may leave only once it is at the head and its age has reached
// LAT, so each response appears LAT cycles after it was pushed, or later
// when the consumer backpressures.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     push side; in_ready is registered from occupancy
//   in_payload [PW]       payload captured on push
//   out_valid/out_ready   pop side
//   out_payload [PW]      head payload, forced to 0 while out_valid is low
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid holds with stable payload until then, and ready never
// depends combinationally on valid.
module resp_delay_queue
  import copperv_bus_pkg::*;
#(
  parameter int PW     = 32,
  parameter int LAT    = 1,
  parameter int QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [BUS_AGE_W-1:0] LAT_AGE  = BUS_AGE_W'(LAT);
  localparam logic [PTR_W:0]       FULL_CNT = (PTR_W+1)'(QDEPTH);

  resp_entry_t    q [QDEPTH];
  resp_entry_t    head;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] wr_next, rd_next, cnt_next;
  logic           push, pop, empty;

  assign empty       = (wr_ptr == rd_ptr);
  assign head        = q[rd_ptr[PTR_W-1:0]];
  assign out_valid   = !empty && (head.age == LAT_AGE);
  assign out_payload = out_valid ? head.payload[PW-1:0] : '0;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign wr_next  = wr_ptr + (PTR_W+1)'(push);
  assign rd_next  = rd_ptr + (PTR_W+1)'(pop);
  assign cnt_next = wr_next - rd_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      // Registered from next occupancy: a pop on a full queue reopens
      // the input one cycle later, never in the same cycle.
      in_ready <= (cnt_next != FULL_CNT);
      // Every slot ages, saturating at LAT; idle slots are harmless since
      // a push restarts the slot's age at 0 (later assignment wins).
      for (int i = 0; i < QDEPTH; i++) begin
        if (q[i].age != LAT_AGE) q[i].age <= q[i].age + BUS_AGE_W'(1);
      end
      if (push) begin
        q[wr_ptr[PTR_W-1:0]] <= '{payload: BUS_MAX_PAYLOAD_W'(in_payload),
                                  age:     '0};
      end
    end
  end

endmodule

// File: rtl/bus_data_responder.sv
// Memory-side responder for the CPU data bus. Holds a word-addressed
// memory; reads sample the word on the address handshake and writes
// update byte lanes on the write handshake. Responses are delayed by
// READ_LATENCY / WRITE_LATENCY through two resp_delay_queue instances.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   dr_addr_valid/ready, dr_addr      read address channel
//   dr_data_valid/ready, dr_data      read data channel
//   dw_data_addr_valid/ready,
//   dw_data, dw_addr, dw_strobe       write request channel
//   dw_resp_valid/ready, dw_resp      write response (0 OKAY, 1 ERROR)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid holds with stable payload until then, and ready never
// depends combinationally on valid.
//
// Build option BUS_RESPONDER_ADDR_CHECK_EN: byte addresses >= DEPTH*4 are
// out of range (reads return DEADBEEF, writes are dropped with ERROR).
// Without it the word index simply wraps modulo DEPTH.
module bus_data_responder
  import copperv_bus_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int QDEPTH        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dr_addr_valid,
  output logic                    dr_addr_ready,
  input  logic [ADDR_WIDTH-1:0]   dr_addr,
  output logic                    dr_data_valid,
  input  logic                    dr_data_ready,
  output logic [DATA_WIDTH-1:0]   dr_data,
  input  logic                    dw_data_addr_valid,
  output logic                    dw_data_addr_ready,
  input  logic [DATA_WIDTH-1:0]   dw_data,
  input  logic [ADDR_WIDTH-1:0]   dw_addr,
  input  logic [DATA_WIDTH/8-1:0] dw_strobe,
  output logic                    dw_resp_valid,
  input  logic                    dw_resp_ready,
  output logic                    dw_resp
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic                  rd_push, wr_push;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;
  logic                  wr_code;
  logic                  unused_addr_bits;

  assign rd_idx  = dr_addr[IDX_W+1:2];
  assign wr_idx  = dw_addr[IDX_W+1:2];
  assign rd_push = dr_addr_valid && dr_addr_ready;
  assign wr_push = dw_data_addr_valid && dw_data_addr_ready;

`ifdef BUS_RESPONDER_ADDR_CHECK_EN
  logic rd_oor, wr_oor;
  assign rd_oor  = |dr_addr[ADDR_WIDTH-1:IDX_W+2];
  assign wr_oor  = |dw_addr[ADDR_WIDTH-1:IDX_W+2];
  assign rd_word = rd_oor ? DATA_WIDTH'(BUS_DEADBEEF) : mem[rd_idx];
  assign wr_en   = wr_push && !wr_oor;
  assign wr_code = wr_oor ? BUS_RESP_ERROR : BUS_RESP_OKAY;
  assign unused_addr_bits = &{1'b0, dr_addr[1:0], dw_addr[1:0]};
`else
  assign rd_word = mem[rd_idx];
  assign wr_en   = wr_push;
  assign wr_code = BUS_RESP_OKAY;
  assign unused_addr_bits = &{1'b0, dr_addr[1:0], dw_addr[1:0],
                              dr_addr[ADDR_WIDTH-1:IDX_W+2],
                              dw_addr[ADDR_WIDTH-1:IDX_W+2]};
`endif

  // Memory is never cleared. The read above is combinational, so a read
  // and write to the same word on one edge capture the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (dw_strobe[b]) mem[wr_idx][8*b +: 8] <= dw_data[8*b +: 8];
      end
    end
  end

  resp_delay_queue #(
    .PW(DATA_WIDTH), .LAT(READ_LATENCY), .QDEPTH(QDEPTH)
  ) u_rd_queue (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (dr_addr_valid),
    .in_ready   (dr_addr_ready),
    .in_payload (rd_word),
    .out_valid  (dr_data_valid),
    .out_ready  (dr_data_ready),
    .out_payload(dr_data)
  );

  resp_delay_queue #(
    .PW(1), .LAT(WRITE_LATENCY), .QDEPTH(QDEPTH)
  ) u_wr_queue (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (dw_data_addr_valid),
    .in_ready   (dw_data_addr_ready),
    .in_payload (wr_code),
    .out_valid  (dw_resp_valid),
    .out_ready  (dw_resp_ready),
    .out_payload(dw_resp)
  );

endmodule

// File: tb/tb_bus_data_responder.sv
// Self-checking bench for bus_data_responder: directed scenarios plus a
// randomized mix checked against a word-array model with expected queues.
module tb_bus_data_responder;

  localparam int DW = 32, AW = 32, DEPTH = 1024, RL = 2, WL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          dr_addr_valid, dr_addr_ready;
  logic [AW-1:0] dr_addr;
  logic          dr_data_valid, dr_data_ready;
  logic [DW-1:0] dr_data;
  logic          dw_data_addr_valid, dw_data_addr_ready;
  logic [DW-1:0] dw_data;
  logic [AW-1:0] dw_addr;
  logic [3:0]    dw_strobe;
  logic          dw_resp_valid, dw_resp_ready, dw_resp;

  bus_data_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL), .QDEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .dw_data_addr_valid(dw_data_addr_valid), .dw_data_addr_ready(dw_data_addr_ready),
    .dw_data(dw_data), .dw_addr(dw_addr), .dw_strobe(dw_strobe),
    .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1);
  end

  int checks = 0;
  int passes = 0;

  // ---------------- reference model ----------------
  logic [31:0] mem_m [0:DEPTH-1];
  logic [31:0] exp_q[$];
  logic [0:0]  exp_w_q[$];
  bit          driver_done;

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit m_oor(input logic [31:0] a);
`ifdef BUS_RESPONDER_ADDR_CHECK_EN
    return a >= DEPTH * 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_oor(a) ? 32'hDEADBEEF : mem_m[m_idx(a)];
  endfunction

  // Applies a strobed write to the model; returns the expected response.
  function automatic logic m_write(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
    logic [31:0] w;
    if (m_oor(a)) return 1'b1;
    w = mem_m[m_idx(a)];
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_m[m_idx(a)] = w;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge or just after a posedge; return 1 time unit after
  // the handshake edge with hc = that edge's cycle number.
  task automatic send_read(input logic [31:0] a, output int hc);
    int n = 0;
    dr_addr = a;
    dr_addr_valid = 1'b1;
    while (!dr_addr_ready && n < 200) begin @(negedge clk); n++; end
    if (!dr_addr_ready) begin
      checks++;
      $display("FAIL rd_accept_timeout addr=%h ready=%b want 1", a, dr_addr_ready);
      dr_addr_valid = 1'b0;
      hc = -1;
      return;
    end
    @(posedge clk); #1;
    hc = cycle;
    dr_addr_valid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int hc);
    int n = 0;
    dw_addr = a; dw_data = d; dw_strobe = s;
    dw_data_addr_valid = 1'b1;
    while (!dw_data_addr_ready && n < 200) begin @(negedge clk); n++; end
    if (!dw_data_addr_ready) begin
      checks++;
      $display("FAIL wr_accept_timeout addr=%h ready=%b want 1", a, dw_data_addr_ready);
      dw_data_addr_valid = 1'b0;
      hc = -1;
      return;
    end
    @(posedge clk); #1;
    hc = cycle;
    dw_data_addr_valid = 1'b0;
  endtask

  // vc = cycle of the first negedge where the response is visible.
  task automatic recv_read(output logic [31:0] d, output int vc);
    int n = 0;
    dr_data_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!dr_data_valid && n < 200);
    if (!dr_data_valid) begin
      checks++;
      $display("FAIL rd_resp_timeout valid=%b want 1", dr_data_valid);
      d = 'x; vc = -1;
    end else begin
      d = dr_data; vc = cycle;
    end
    @(posedge clk); #1;
  endtask

  task automatic recv_write(output logic r, output int vc);
    int n = 0;
    dw_resp_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!dw_resp_valid && n < 200);
    if (!dw_resp_valid) begin
      checks++;
      $display("FAIL wr_resp_timeout valid=%b want 1", dw_resp_valid);
      r = 'x; vc = -1;
    end else begin
      r = dw_resp; vc = cycle;
    end
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    int hc, vc;
    logic r, er;
    send_write(a, d, 4'hF, hc);
    er = m_write(a, d, 4'hF);
    recv_write(r, vc);
    checks++;
    if (r !== er) $display("FAIL preload_resp addr=%h got %b want %b", a, r, er);
    else passes++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dr_addr_ready, dw_data_addr_ready, dr_data_valid, dw_resp_valid, dw_resp, dr_data} !== '0)
      $display("FAIL reset_outputs got %b_%b_%b_%b_%b_%h want all 0", dr_addr_ready,
               dw_data_addr_ready, dr_data_valid, dw_resp_valid, dw_resp, dr_data);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({dr_addr_ready, dw_data_addr_ready} !== 2'b00)
      $display("FAIL ready_before_edge got %b%b want 00", dr_addr_ready, dw_data_addr_ready);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({dr_addr_ready, dw_data_addr_ready} !== 2'b11)
      $display("FAIL ready_after_edge got %b%b want 11", dr_addr_ready, dw_data_addr_ready);
    else passes++;
  endtask

  task automatic test_write_read();
    int hc, vc;
    logic r, er;
    logic [31:0] d, ed;
    send_write(32'h10, 32'h12345678, 4'hF, hc);
    er = m_write(32'h10, 32'h12345678, 4'hF);
    recv_write(r, vc);
    checks++;
    if (r !== er) $display("FAIL wr_resp got %b want %b", r, er); else passes++;
    checks++;
    if (vc - hc !== WL) $display("FAIL wr_latency got %0d want %0d", vc - hc, WL); else passes++;
    send_read(32'h10, hc);
    ed = m_read(32'h10);
    recv_read(d, vc);
    checks++;
    if (d !== ed) $display("FAIL rd_data got %h want %h", d, ed); else passes++;
    checks++;
    if (vc - hc !== RL) $display("FAIL rd_latency got %0d want %0d", vc - hc, RL); else passes++;
  endtask

  task automatic test_strobe();
    int hc, vc;
    logic r, er;
    logic [31:0] d, ed;
    preload(32'h20, 32'hFFFFFFFF);
    send_write(32'h20, 32'h000000AA, 4'b0001, hc);
    er = m_write(32'h20, 32'h000000AA, 4'b0001);
    recv_write(r, vc);
    checks++;
    if (r !== er) $display("FAIL strobe_resp got %b want %b", r, er); else passes++;
    send_read(32'h20, hc);
    ed = m_read(32'h20);
    recv_read(d, vc);
    checks++;
    if (d !== ed) $display("FAIL strobe_data got %h want %h", d, ed); else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [3];
    logic [31:0] got[$];
    int acc_k = -1;
    bit hs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      preload(32'h40 + 4 * i, $urandom);
      ed[i] = m_read(32'h40 + 4 * i);
    end
    dr_data_ready = 1'b0;
    dr_addr = 32'h40; dr_addr_valid = 1'b1;
    @(posedge clk); #1;
    dr_addr = 32'h44;
    @(posedge clk); #1;
    dr_addr = 32'h48;
    @(negedge clk);
    checks++;
    if (dr_addr_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", dr_addr_ready);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if ({dr_data_valid, dr_data, dr_addr_ready} !== {1'b1, ed[0], 1'b0})
      $display("FAIL bp_hold got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
               dr_data_valid, dr_data, dr_addr_ready, ed[0]);
    else passes++;
    @(posedge clk); #1;
    dr_data_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dr_data_valid) got.push_back(dr_data);
      if (dr_addr_valid && dr_addr_ready) begin acc_k = k; hs = 1'b1; end
      @(posedge clk); #1;
      if (hs) begin dr_addr_valid = 1'b0; hs = 1'b0; end
      if (got.size() == 3 && !dr_addr_valid) break;
    end
    dr_addr_valid = 1'b0;
    checks++;
    if (acc_k !== 1) $display("FAIL bp_third_accept got k=%0d want 1", acc_k); else passes++;
    checks++;
    if (got.size() !== 3) $display("FAIL bp_count got %0d want 3", got.size()); else passes++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ed[i]) $display("FAIL bp_order[%0d] got %h want %h", i, got[i], ed[i]);
      else passes++;
    end
  endtask

  task automatic test_same_cycle();
    int hc, vc1, vc2;
    logic r, er;
    logic [31:0] d, ed;
    preload(32'h30, 32'h1);
    dr_addr = 32'h30; dr_addr_valid = 1'b1;
    dw_addr = 32'h30; dw_data = 32'h2; dw_strobe = 4'hF; dw_data_addr_valid = 1'b1;
    checks++;
    if ({dr_addr_ready, dw_data_addr_ready} !== 2'b11)
      $display("FAIL same_ready got %b%b want 11", dr_addr_ready, dw_data_addr_ready);
    else passes++;
    @(posedge clk); #1;
    dr_addr_valid = 1'b0; dw_data_addr_valid = 1'b0;
    ed = m_read(32'h30);
    er = m_write(32'h30, 32'h2, 4'hF);
    fork
      recv_write(r, vc1);
      recv_read(d, vc2);
    join
    checks++;
    if (d !== ed) $display("FAIL same_old_data got %h want %h", d, ed); else passes++;
    checks++;
    if (r !== er) $display("FAIL same_resp got %b want %b", r, er); else passes++;
    send_read(32'h30, hc);
    ed = m_read(32'h30);
    recv_read(d, vc1);
    checks++;
    if (d !== ed) $display("FAIL same_new_data got %h want %h", d, ed); else passes++;
  endtask

  task automatic test_addr_check();
    int hc, vc;
    logic r, er;
    logic [31:0] d, ed, wd;
    wd = $urandom;
    preload(32'h0, ~wd);
    send_write(32'h1000, wd, 4'hF, hc);
    er = m_write(32'h1000, wd, 4'hF);
    recv_write(r, vc);
    checks++;
    if (r !== er) $display("FAIL oor_resp got %b want %b", r, er); else passes++;
    send_read(32'h1000, hc);
    ed = m_read(32'h1000);
    recv_read(d, vc);
    checks++;
    if (d !== ed) $display("FAIL oor_read got %h want %h", d, ed); else passes++;
    send_read(32'h0, hc);
    ed = m_read(32'h0);
    recv_read(d, vc);
    checks++;
    if (d !== ed) $display("FAIL alias_word0 got %h want %h", d, ed); else passes++;
  endtask

  task automatic test_reset_mid();
    int hc, vc, bad;
    logic [31:0] d, ed;
    preload(32'h50, $urandom);
    send_read(32'h50, hc);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({dr_data_valid, dr_addr_ready, dw_data_addr_ready} !== 3'b000)
      $display("FAIL midrst_outputs got %b%b%b want 000", dr_data_valid, dr_addr_ready,
               dw_data_addr_ready);
    else passes++;
    bad = 0;
    repeat (2) begin @(negedge clk); if (dr_data_valid) bad++; end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); if (dr_data_valid) bad++; end
    checks++;
    if (bad !== 0) $display("FAIL midrst_flushed got %0d valid cycles want 0", bad);
    else passes++;
    send_read(32'h50, hc);
    ed = m_read(32'h50);
    recv_read(d, vc);
    checks++;
    if (d !== ed) $display("FAIL midrst_read got %h want %h", d, ed); else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) preload(4 * i, $urandom);
    driver_done = 1'b0;
    fork
      begin : driver
        int hc;
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int i = 0; i < 80; i++) begin
          a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
          if ($urandom_range(0, 1) == 1) begin
            send_read(a, hc);
            exp_q.push_back(m_read(a));
          end else begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            send_write(a, d, s, hc);
            exp_w_q.push_back(m_write(a, d, s));
          end
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        driver_done = 1'b1;
      end
      begin : rd_consumer
        int n = 0;
        logic [31:0] e;
        while (!(driver_done && exp_q.size() == 0) && n < 5000) begin
          @(negedge clk); n++;
          dr_data_ready = 1'($urandom_range(0, 1));
          if (dr_data_valid && dr_data_ready) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL rand_rd_extra got %h want none", dr_data);
            else begin
              e = exp_q.pop_front();
              if (dr_data !== e) $display("FAIL rand_rd_data got %h want %h", dr_data, e);
              else passes++;
            end
          end
        end
        if (n >= 5000) begin checks++; $display("FAIL rand_rd_timeout left=%0d want 0", exp_q.size()); end
        dr_data_ready = 1'b1;
      end
      begin : wr_consumer
        int n = 0;
        logic [0:0] e;
        while (!(driver_done && exp_w_q.size() == 0) && n < 5000) begin
          @(negedge clk); n++;
          dw_resp_ready = 1'($urandom_range(0, 1));
          if (dw_resp_valid && dw_resp_ready) begin
            checks++;
            if (exp_w_q.size() == 0) $display("FAIL rand_wr_extra got %b want none", dw_resp);
            else begin
              e = exp_w_q.pop_front();
              if (dw_resp !== e) $display("FAIL rand_wr_resp got %b want %b", dw_resp, e);
              else passes++;
            end
          end
        end
        if (n >= 5000) begin checks++; $display("FAIL rand_wr_timeout left=%0d want 0", exp_w_q.size()); end
        dw_resp_ready = 1'b1;
      end
    join
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    dr_addr_valid = 1'b0; dr_addr = '0; dr_data_ready = 1'b1;
    dw_data_addr_valid = 1'b0; dw_data = '0; dw_addr = '0; dw_strobe = '0;
    dw_resp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_strobe();
    test_backpressure();
    test_same_cycle();
    test_addr_check();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
